note_sequencer: RTL and testbench

//  Record/playback controller for the piano key-capture block. In RECORD it stores each completed note

---
 rtl/note_sequencer_if.sv | 32 +++
 rtl/note_sequencer.sv | 176 +++++++++++++++++
 tb/tb_note_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: command, note-capture and playback signals of the
// piano note sequencer, bundled as one interface.
//  master: drives rec_start/play_start/stop and note_* and observes
//          play_key/state/note_count/overflow/done (controller side).
//  slave : the sequencer itself.
interface note_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int TIME_W = 13
);
  logic              rec_start;
  logic              play_start;
  logic              stop;
  logic              note_valid;
  logic [1:0]        note_key;
  logic [TIME_W-1:0] note_start;
  logic [TIME_W-1:0] note_dur;
  logic [1:0]        play_key;
  logic [1:0]        state;
  logic [ADDR_W:0]   note_count;
  logic              overflow;
  logic              done;

  modport master (
    output rec_start, play_start, stop, note_valid, note_key, note_start, note_dur,
    input  play_key, state, note_count, overflow, done
  );

  modport slave (
    input  rec_start, play_start, stop, note_valid, note_key, note_start, note_dur,
    output play_key, state, note_count, overflow, done
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: record/playback controller between the key-capture block
// and the tone generator. RECORD stores completed notes (key, start rebased
// to the first note, duration); PLAY replays them one at a time on play_key
// with a time base of TICK_CYCLES clocks per tick (0.01 s).
// Ports:
//  CLOCK_50 - system clock
//  reset_n  - asynchronous active-low reset
//  bus      - note_sequencer_if.slave: commands and note fields in,
//             play_key/state/note_count/overflow/done out (all registered)
module note_sequencer #(
  parameter int TICK_CYCLES = 500000,
  parameter int ADDR_W      = 5,
  parameter int TIME_W      = 13
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  note_sequencer_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TCW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TCW-1:0]  TCNT_MAX  = TCW'(TICK_CYCLES - 1);
  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RECORD    = 2'b01,
    PLAY_WAIT = 2'b10,
    PLAY_NOTE = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        key_q, key_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TIME_W-1:0] remain_q, remain_d;
  logic [TIME_W-1:0] ptime_q, ptime_d;
  logic [TCW-1:0]    tcnt_q, tcnt_d;
  logic              tick;
  logic              wr_en;
  logic [TIME_W-1:0] wr_start;

  // Note buffer; contents are data only and are never reset.
  logic [1:0]        key_mem   [DEPTH];
  logic [TIME_W-1:0] start_mem [DEPTH];
  logic [TIME_W-1:0] dur_mem   [DEPTH];
  logic [TIME_W-1:0] base_q;

  logic [1:0]        key_rd;
  logic [TIME_W-1:0] start_rd;
  logic [TIME_W-1:0] dur_rd;

  assign key_rd   = key_mem[idx_q];
  assign start_rd = start_mem[idx_q];
  assign dur_rd   = dur_mem[idx_q];

  // The first stored note defines time zero; later starts are offsets from it
  // modulo 2**TIME_W so a capture clock wrap between notes is harmless.
  assign wr_start = (count_q == '0) ? '0 : bus.note_start - base_q;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    done_d   = 1'b0;
    count_d  = count_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;
    remain_d = remain_q;
    ptime_d  = ptime_q;
    tcnt_d   = tcnt_q;
    wr_en    = 1'b0;

    tick = (state_q == PLAY_WAIT || state_q == PLAY_NOTE) && (tcnt_q == TCNT_MAX);

    if (state_q == PLAY_WAIT || state_q == PLAY_NOTE) begin
      tcnt_d = tick ? '0 : tcnt_q + 1'b1;
      if (tick) ptime_d = ptime_q + 1'b1;
    end

    if (bus.stop) begin
      state_d = IDLE;
      key_d   = 2'b00;
    end else if (bus.rec_start) begin
      state_d = RECORD;
      key_d   = 2'b00;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.play_start && count_q != '0) begin
            state_d = PLAY_WAIT;
            idx_d   = '0;
            ptime_d = '0;
            tcnt_d  = '0;
          end
        end
        RECORD: begin
          if (bus.note_valid && bus.note_key != 2'b00) begin
            if (count_q == COUNT_MAX) begin
              ovf_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              count_d = count_q + 1'b1;
            end
          end
        end
        PLAY_WAIT: begin
          // ">=" rather than "==" lets an overlapped note start as soon as
          // the previous one has finished.
          if (ptime_q >= start_rd) begin
            state_d  = PLAY_NOTE;
            key_d    = key_rd;
            remain_d = (dur_rd == '0) ? TIME_W'(1) : dur_rd;
          end
        end
        PLAY_NOTE: begin
          if (tick) begin
            remain_d = remain_q - 1'b1;
            if (remain_q == TIME_W'(1)) begin
              key_d = 2'b00;
              idx_d = idx_q + 1'b1;
              if ({1'b0, idx_q} + 1'b1 == count_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = PLAY_WAIT;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      key_q    <= 2'b00;
      done_q   <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
      remain_q <= '0;
      ptime_q  <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      done_q   <= done_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
      ptime_q  <= ptime_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      key_mem[count_q[ADDR_W-1:0]]   <= bus.note_key;
      start_mem[count_q[ADDR_W-1:0]] <= wr_start;
      dur_mem[count_q[ADDR_W-1:0]]   <= bus.note_dur;
      if (count_q == '0) base_q <= bus.note_start;
    end
  end

  assign bus.play_key   = key_q;
  assign bus.state      = state_q;
  assign bus.note_count = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench for note_sequencer with TICK_CYCLES=4.
// A small note-list model predicts the play_key/done event sequence and tick
// numbers; a negedge monitor pops and compares them as the DUT plays.
module tb_note_sequencer;
  localparam int TICK   = 4;
  localparam int ADDR_W = 5;
  localparam int TIME_W = 13;
  localparam int DEPTH  = 32;

  typedef struct {
    int kind;   // 0 = play_key change, 1 = done pulse
    int key;
    int tick;
  } evt_t;

  typedef struct {
    int key;
    int start;
    int dur;
  } note_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  note_sequencer_if #(.ADDR_W(ADDR_W), .TIME_W(TIME_W)) bus ();

  note_sequencer #(.TICK_CYCLES(TICK), .ADDR_W(ADDR_W), .TIME_W(TIME_W)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    play_cyc = 0;
  logic  mon_en = 1'b0;
  logic [1:0] last_key = 2'b00;
  evt_t  sb [$];
  note_t notes [$];
  int    base  = 0;
  int    m_ovf = 0;
  int    mon_c;
  evt_t  mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_c = cyc - play_cyc;
      if (bus.play_key !== last_key) begin
        if (sb.size() == 0) begin
          check_val("extra_key", bus.play_key, last_key);
        end else begin
          mon_e = sb.pop_front();
          check_val("evt_kind", 0, mon_e.kind);
          check_val("key", bus.play_key, mon_e.key);
          check_val("key_tick", mon_c / TICK, mon_e.tick);
        end
        last_key = bus.play_key;
      end
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          check_val("extra_done", bus.done, 0);
        end else begin
          mon_e = sb.pop_front();
          check_val("evt_kind", 1, mon_e.kind);
          check_val("done_tick", mon_c / TICK, mon_e.tick);
        end
      end
    end
  end

  task automatic rec_start();
    notes.delete();
    m_ovf = 0;
    bus.rec_start = 1'b1;
    @(posedge clk); #1;
    bus.rec_start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
  endtask

  task automatic send_note(input int key, input int st, input int dur);
    bus.note_valid = 1'b1;
    bus.note_key   = key[1:0];
    bus.note_start = st[TIME_W-1:0];
    bus.note_dur   = dur[TIME_W-1:0];
    @(posedge clk); #1;
    bus.note_valid = 1'b0;
    if (key != 0) begin
      if (notes.size() < DEPTH) begin
        if (notes.size() == 0) base = st;
        notes.push_back('{key: key, start: (st - base) & ((1 << TIME_W) - 1), dur: dur});
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic start_play();
    last_key = 2'b00;
    bus.play_start = 1'b1;
    @(posedge clk); #1;
    bus.play_start = 1'b0;
    play_cyc = cyc;
    mon_en = 1'b1;
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_val("sb_drain", sb.size(), 0);
    sb.delete();
    mon_en = 1'b0;
  endtask

  // Sequential playback model: a note starts at its start tick or when the
  // previous note ends, whichever is later, and lasts max(dur,1) ticks.
  task automatic play_all(input int budget);
    int t = 0;
    int on;
    foreach (notes[i]) begin
      on = (notes[i].start > t) ? notes[i].start : t;
      sb.push_back('{kind: 0, key: notes[i].key, tick: on});
      t = on + ((notes[i].dur == 0) ? 1 : notes[i].dur);
      sb.push_back('{kind: 0, key: 0, tick: t});
    end
    sb.push_back('{kind: 1, key: 0, tick: t});
    start_play();
    wait_sb(budget);
    check_val("end_state", bus.state, 0);
    check_val("done_clear", bus.done, 0);
  endtask

  // Start playback and return once the first note is sounding.
  task automatic play_first(input int budget);
    sb.push_back('{kind: 0, key: notes[0].key, tick: notes[0].start});
    start_play();
    wait_sb(budget);
  endtask

  initial begin
    int cnt;
    bus.rec_start  = 1'b0;
    bus.play_start = 1'b0;
    bus.stop       = 1'b0;
    bus.note_valid = 1'b0;
    bus.note_key   = 2'b00;
    bus.note_start = '0;
    bus.note_dur   = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    check_val("rst_state", bus.state, 0);
    check_val("rst_key", bus.play_key, 0);
    check_val("rst_count", bus.note_count, 0);
    check_val("rst_ovf", bus.overflow, 0);
    check_val("rst_done", bus.done, 0);

    // Three spaced notes
    rec_start();
    check_val("rec_state", bus.state, 1);
    send_note(1, 100, 5);
    send_note(2, 110, 3);
    send_note(3, 120, 2);
    check_val("count3", bus.note_count, notes.size());
    do_stop();
    play_all(300);

    // Overlapping notes play back to back
    rec_start();
    send_note(1, 0, 10);
    send_note(2, 5, 3);
    do_stop();
    play_all(300);

    // Zero duration and capture-time wrap between notes
    rec_start();
    send_note(1, 8190, 0);
    send_note(2, 3, 2);
    do_stop();
    play_all(200);

    // Buffer full, overflow, key-0 note ignored, rec_start clears
    rec_start();
    for (int i = 0; i < 33; i++) send_note((i % 3) + 1, 2 * i, 1);
    check_val("count_full", bus.note_count, notes.size());
    check_val("ovf_set", bus.overflow, m_ovf);
    send_note(0, 500, 1);
    check_val("count_key0", bus.note_count, notes.size());
    rec_start();
    check_val("ovf_clear", bus.overflow, m_ovf);
    check_val("count_clear", bus.note_count, 0);

    // stop during PLAY_NOTE: silent next cycle, no done
    send_note(1, 0, 20);
    do_stop();
    play_first(50);
    check_val("pn_state", bus.state, 3);
    do_stop();
    check_val("stop_key", bus.play_key, 0);
    check_val("stop_state", bus.state, 0);
    cnt = 0;
    repeat (120) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
    @(posedge clk); #1;
    check_val("stop_no_done", cnt, 0);

    // play_start with empty buffer is ignored
    rec_start();
    do_stop();
    bus.play_start = 1'b1;
    @(posedge clk); #1;
    bus.play_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_val("empty_play", bus.state, 0);

    // Asynchronous reset in the middle of playback
    rec_start();
    send_note(2, 40, 30);
    send_note(3, 50, 5);
    do_stop();
    play_first(50);
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b0;
    #2;
    check_val("mid_rst_key", bus.play_key, 0);
    check_val("mid_rst_state", bus.state, 0);
    check_val("mid_rst_count", bus.note_count, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    notes.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
